// File: rtl/instrmem_pkg.sv
// instrmem_pkg: shared instruction-memory parameters, loader state codes and byte-address to index mapping.
package instrmem_pkg;
  localparam int IMEM_AW = 12;
  localparam int IMEM_DW = 16;
  localparam int MAX_WORDS = 2048;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_LEN_HI  = 3'd1;
  localparam state_t S_LEN_LO  = 3'd2;
  localparam state_t S_DATA_HI = 3'd3;
  localparam state_t S_DATA_LO = 3'd4;
  localparam state_t S_CSUM    = 3'd5;
  localparam state_t S_DONE    = 3'd6;
  function automatic logic [IMEM_AW-1:0] byte_to_index(input logic [IMEM_AW-1:0] a);
    return {a[IMEM_AW-1], a[IMEM_AW-1:1]};
  endfunction
endpackage

// File: rtl/instrmem_loader_csum.sv
// instrmem_loader_csum: 8-bit XOR accumulator with synchronous clear and enable.
module instrmem_loader_csum (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);
  logic [7:0] sum_q, sum_d;
  assign sum_d = clr_i ? 8'h00 : en_i ? sum_q ^ data_i : sum_q;
  assign sum_o = sum_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sum_q <= 8'h00;
    else sum_q <= sum_d;
endmodule

// File: rtl/instrmem_loader.sv
// instrmem_loader: fills instruction memory from a byte stream (length, then big-endian halfwords).
// Define INSTRMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module instrmem_loader
  import instrmem_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [IMEM_AW-1:0] base_addr_i,
  input  logic [7:0]         in_data_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic               wr_en_o,
  output logic [IMEM_AW-1:0] wr_addr_o,
  output logic [IMEM_DW-1:0] wr_data_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               error_o
);
  state_t             state_q, state_d;
  logic [IMEM_AW-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         hi_q, hi_d;
  logic [IMEM_DW-1:0] wr_data_q, wr_data_d;
  logic               wr_en_q, wr_en_d, done_q, done_d, error_q, error_d;
  logic               xfer, accept_start;
  logic [15:0]        len;
  assign in_ready_o = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM};
  assign busy_o = (state_q != S_IDLE) && (state_q != S_DONE);
  assign xfer = in_valid_i && in_ready_o;
  assign accept_start = (state_q == S_IDLE) && start_i;
  assign len = {hi_q, in_data_i};
  assign wr_en_o = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign done_o = done_q;
  assign error_o = error_q;
`ifdef INSTRMEM_LOADER_CSUM_EN
  logic [7:0] sum;
  instrmem_loader_csum u_csum (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (accept_start),
    .en_i   (xfer && (state_q inside {S_DATA_HI, S_DATA_LO})),
    .data_i (in_data_i),
    .sum_o  (sum)
  );
`endif
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d = done_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_LEN_HI;
        addr_d = {base_addr_i[IMEM_AW-1:1], 1'b0};
        cnt_d = 16'd0;
        done_d = 1'b0;
        error_d = 1'b0;
      end
      S_LEN_HI: if (xfer) begin
        hi_d = in_data_i;
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (xfer) begin
        cnt_d = len;
        if (len == 16'd0) begin
          state_d = S_DONE;
          done_d = 1'b1;
        end else if (len > 16'(MAX_WORDS)) begin
          state_d = S_IDLE;
          done_d = 1'b1;
          error_d = 1'b1;
        end else state_d = S_DATA_HI;
      end
      S_DATA_HI: if (xfer) begin
        hi_d = in_data_i;
        state_d = S_DATA_LO;
      end
      S_DATA_LO: if (xfer) begin
        wr_en_d = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = {hi_q, in_data_i};
        addr_d = addr_q + 12'd2;
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
`ifdef INSTRMEM_LOADER_CSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_DONE;
          done_d = 1'b1;
`endif
        end else state_d = S_DATA_HI;
      end
`ifdef INSTRMEM_LOADER_CSUM_EN
      S_CSUM: if (xfer) begin
        state_d = S_DONE;
        done_d = 1'b1;
        error_d = in_data_i != sum;
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A write registered by this cycle's DATA_LO still issues; only the state is cancelled.
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      done_d = 1'b0;
      error_d = 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      hi_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q <= done_d;
      error_q <= error_d;
    end
endmodule

// File: tb/tb_instrmem_loader.sv
// tb_instrmem_loader: scoreboard bench for instrmem_loader; expected writes are queued, a monitor compares.
module tb_instrmem_loader;
  import instrmem_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [11:0] base_addr = '0;
  logic [7:0]  in_data = '0;
  logic        in_ready, wr_en, busy, done, error;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  int checks = 0, failures = 0, wr_cnt = 0;
  typedef struct {logic [11:0] a; logic [15:0] d; logic [11:0] i;} wr_t;
  wr_t sb[$];
  logic [7:0] stim[$];
  instrmem_loader dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort), .base_addr_i(base_addr),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready), .wr_en_o(wr_en),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy), .done_o(done), .error_o(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) if (wr_en) begin
    wr_t e;
    wr_cnt++;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", wr_addr, wr_data);
    end else begin
      e = sb.pop_front();
      chk("wr_addr", int'(wr_addr), int'(e.a));
      chk("wr_data", int'(wr_data), int'(e.d));
      chk("wr_index", int'(byte_to_index(wr_addr)), int'(e.i));
    end
  end
  task automatic push(input logic [11:0] a, input logic [15:0] d, input logic [11:0] i);
    wr_t e;
    e.a = a; e.d = d; e.i = i;
    sb.push_back(e);
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_start(input logic [11:0] b);
    start = 1'b1; base_addr = b;
    tick();
    start = 1'b0;
    chk("in_ready_after_start", int'(in_ready), 1);
    chk("busy_after_start", int'(busy), 1);
  endtask
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit ok = 1'b0;
    int n = 0;
    if (rnd) repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0; start = 1'b1; base_addr = 12'h300;
      tick();
      start = 1'b0;
    end
    in_valid = 1'b1; in_data = b;
    while (!ok && n < 50) begin
      @(negedge clk); ok = in_ready;
      tick(); n++;
    end
    in_valid = 1'b0;
    if (!ok) chk("byte_timeout", 0, 1);
  endtask
  task automatic send_stim(input bit rnd, input bit add_csum);
    logic [7:0] x = 8'h00;
    foreach (stim[k]) begin
      send_byte(stim[k], rnd);
      if (k >= 2) x ^= stim[k];
    end
    if (add_csum) begin
`ifdef INSTRMEM_LOADER_CSUM_EN
      send_byte(x, rnd);
`endif
    end
  endtask
  initial begin
    int w0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    rst_n = 1'b1;
    tick();
    // Basic two-word load
    push(12'h010, 16'h1234, 12'h008);
    push(12'h012, 16'hABCD, 12'h009);
    do_start(12'h011);
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_stim(1'b0, 1'b1);
`ifndef INSTRMEM_LOADER_CSUM_EN
    chk("wr_en_with_done", int'(wr_en), 1);
`endif
    chk("t1_done", int'(done), 1);
    chk("t1_error", int'(error), 0);
    chk("t1_busy", int'(busy), 0);
    tick();
    chk("t1_done_held", int'(done), 1);
    // Address wrap
    push(12'hFFE, 16'h1111, 12'hFFF);
    push(12'h000, 16'h2222, 12'h000);
    do_start(12'hFFE);
    stim = '{8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22};
    send_stim(1'b0, 1'b1);
    chk("t2_done", int'(done), 1);
    chk("t2_error", int'(error), 0);
    tick(); tick();
    // Oversize count
    w0 = wr_cnt;
    do_start(12'h200);
    chk("t3_done_cleared", int'(done), 0);
    stim = '{8'h08, 8'h01};
    send_stim(1'b0, 1'b0);
    chk("t3_error", int'(error), 1);
    chk("t3_done", int'(done), 1);
    chk("t3_in_ready", int'(in_ready), 0);
    repeat (4) tick();
    chk("t3_no_writes", wr_cnt - w0, 0);
    // Zero count
    do_start(12'h200);
    stim = '{8'h00, 8'h00};
    send_stim(1'b0, 1'b0);
    chk("t3z_done", int'(done), 1);
    chk("t3z_error", int'(error), 0);
    repeat (3) tick();
    chk("t3z_no_writes", wr_cnt - w0, 0);
    // Abort after high byte of the second of three words
    push(12'h100, 16'hAABB, 12'h080);
    do_start(12'h100);
    stim = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    send_stim(1'b0, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_busy", int'(busy), 0);
    chk("t4_error", int'(error), 1);
    chk("t4_done", int'(done), 0);
    chk("t4_in_ready", int'(in_ready), 0);
    repeat (4) tick();
    push(12'h020, 16'h5566, 12'h010);
    do_start(12'h020);
    stim = '{8'h00, 8'h01, 8'h55, 8'h66};
    send_stim(1'b0, 1'b1);
    chk("t4b_done", int'(done), 1);
    chk("t4b_error", int'(error), 0);
    tick(); tick();
`ifdef INSTRMEM_LOADER_CSUM_EN
    push(12'h040, 16'h1234, 12'h020);
    do_start(12'h040);
    stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h26};
    send_stim(1'b0, 1'b0);
    chk("t5_done", int'(done), 1);
    chk("t5_error", int'(error), 0);
    tick(); tick();
    push(12'h040, 16'h1234, 12'h020);
    do_start(12'h040);
    stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    send_stim(1'b0, 1'b0);
    chk("t5b_done", int'(done), 1);
    chk("t5b_error", int'(error), 1);
    tick(); tick();
`endif
    // Random in_valid gaps with start asserted while busy
    push(12'h010, 16'h1234, 12'h008);
    push(12'h012, 16'hABCD, 12'h009);
    do_start(12'h010);
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send_stim(1'b1, 1'b1);
    chk("t6_done", int'(done), 1);
    chk("t6_error", int'(error), 0);
    tick(); tick();
    // Asynchronous reset mid-load clears outputs immediately
    do_start(12'h080);
    stim = '{8'h00, 8'h02, 8'h12, 8'h34};
    send_stim(1'b0, 1'b0);
    chk("t7_wr_en_before_rst", int'(wr_en), 1);
    rst_n = 1'b0;
    #1;
    chk("t7_wr_en", int'(wr_en), 0);
    chk("t7_busy", int'(busy), 0);
    chk("t7_in_ready", int'(in_ready), 0);
    chk("t7_wr_addr", int'(wr_addr), 0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
